// File: rtl/osc_seq_pkg.sv
// Shared types and default sizing for the oscillator ready sequencer.
package osc_seq_pkg;

    localparam int DEF_NCH   = 2;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        OFF,
        WAIT,
        SETTLE,
        READY
    } osc_state_e;

endpackage

// File: rtl/osc_ch_fsm.sv
// One oscillator channel: request / grant / settle-count / ready sequencing
// with registered status outputs.
module osc_ch_fsm
    import osc_seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             grant,
    input  logic [CNT_W-1:0] settle_cnt,
    output logic             is_wait,
    output logic             is_settle,
    output logic             slot_held,
    output logic             osc_en,
    output logic             rdy
);

    osc_state_e       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             osc_en_d, rdy_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= OFF;
            cnt    <= '0;
            osc_en <= 1'b0;
            rdy    <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            osc_en <= osc_en_d;
            rdy    <= rdy_d;
        end
    end

    // NOTE: defaults at the top of the block keep every path assigned,
    // so no latch is inferred for state_d or cnt_d.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (!en) begin
            state_d = OFF;
        end else begin
            unique case (state)
                OFF:    state_d = WAIT;
                WAIT: begin
                    if (grant) begin
                        state_d = SETTLE;
                        cnt_d   = settle_cnt;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) state_d = READY;
                    else           cnt_d   = cnt - CNT_W'(1);
                end
                READY:  state_d = READY;
            endcase
        end
    end

    // A channel on its last settle count frees the stagger slot early so the
    // next waiter enters SETTLE on the same edge this one reaches READY.
    always_comb begin
        is_wait   = (state == WAIT);
        is_settle = (state == SETTLE);
        slot_held = (state == SETTLE) && (cnt != '0);
        osc_en_d  = (state == SETTLE) || (state == READY);
        rdy_d     = (state == READY);
    end

endmodule

// File: rtl/osc_ready_seq.sv
// Multi-channel oscillator ready sequencer: per-channel FSMs plus the
// parallel / staggered settle grant arbiter.
module osc_ready_seq #(
    parameter int NCH   = osc_seq_pkg::DEF_NCH,
    parameter int CNT_W = osc_seq_pkg::DEF_CNT_W
) (
    input  logic                 HCLK,
    input  logic                 RESET,
    input  logic [NCH-1:0]       EN,
    input  logic [NCH*CNT_W-1:0] SETTLE,
    input  logic                 STAGGER,
    output logic [NCH-1:0]       OSC_EN,
    output logic [NCH-1:0]       RDY,
    output logic                 BUSY
);

    logic [NCH-1:0] wait_vec;
    logic [NCH-1:0] settle_vec;
    logic [NCH-1:0] held_vec;
    logic [NCH-1:0] grant;

    // Staggered mode isolates the lowest-index waiter (v & ~(v-1)) and only
    // while no channel still holds the settle slot.
    always_comb begin
        if (!STAGGER)
            grant = wait_vec;
        else if (|held_vec)
            grant = '0;
        else
            grant = wait_vec & ~(wait_vec - NCH'(1));
    end

    always_ff @(posedge HCLK) begin
        if (RESET) BUSY <= 1'b0;
        else       BUSY <= |settle_vec;
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        osc_ch_fsm #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk        (HCLK),
            .rst        (RESET),
            .en         (EN[i]),
            .grant      (grant[i]),
            .settle_cnt (SETTLE[i*CNT_W +: CNT_W]),
            .is_wait    (wait_vec[i]),
            .is_settle  (settle_vec[i]),
            .slot_held  (held_vec[i]),
            .osc_en     (OSC_EN[i]),
            .rdy        (RDY[i])
        );
    end

endmodule
